seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/div_pkg.sv | 12 +
 rtl/div_trial_sub.sv | 18 +
 rtl/seq_divider.sv | 134 +++++++++++++
 tb/tb_seq_divider.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: FSM state encoding and the default width.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_WIDTH = 4;

endpackage

// File: rtl/div_trial_sub.sv
// Combinational (WIDTH+1)-bit trial subtractor for one restoring-division step.
module div_trial_sub
    import div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH:0] minuend,
    input  logic [WIDTH:0] subtrahend,
    output logic [WIDTH:0] diff,
    output logic           neg
);

    // The extra top bit of the wide result is the borrow, i.e. the trial went negative.
    always_comb begin
        {neg, diff} = {1'b0, minuend} - {1'b0, subtrahend};
    end

endmodule

// File: rtl/seq_divider.sv
// Restoring sequential divider, one quotient bit per cycle, MSB first.
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands (magnitude divide plus sign fix-up).
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Start,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             DivByZero
);

    localparam int CW = $clog2(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] quo_sr;
    logic [WIDTH-1:0] dvs_r;
    logic [WIDTH-1:0] rem_r;
    logic [CW-1:0]    step;

    logic [WIDTH:0]   trial_a;
    logic [WIDTH:0]   trial_diff;
    logic             trial_neg;
    logic             unused_diff_msb;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] r_next;
    logic [WIDTH-1:0] q_fin;
    logic [WIDTH-1:0] r_fin;
    logic [WIDTH-1:0] dvd_in;
    logic [WIDTH-1:0] dvs_in;

    // The dividend shifts out of quo_sr's top while quotient bits shift in at the bottom.
    assign trial_a = {rem_r, quo_sr[WIDTH-1]};

    div_trial_sub #(.WIDTH(WIDTH)) u_trial (
        .minuend    (trial_a),
        .subtrahend ({1'b0, dvs_r}),
        .diff       (trial_diff),
        .neg        (trial_neg)
    );

    assign unused_diff_msb = trial_diff[WIDTH];
    assign q_next = {quo_sr[WIDTH-2:0], ~trial_neg};
    assign r_next = trial_neg ? trial_a[WIDTH-1:0] : trial_diff[WIDTH-1:0];

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic q_neg;
    logic r_neg;

    assign dvd_in = Dividend[WIDTH-1] ? -Dividend : Dividend;
    assign dvs_in = Divisor[WIDTH-1]  ? -Divisor  : Divisor;
    assign q_fin  = q_neg ? -q_next : q_next;
    assign r_fin  = r_neg ? -r_next : r_next;
`else
    assign dvd_in = Dividend;
    assign dvs_in = Divisor;
    assign q_fin  = q_next;
    assign r_fin  = r_next;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            Quotient  <= '0;
            Remainder <= '0;
            DivByZero <= 1'b0;
            quo_sr    <= '0;
            dvs_r     <= '0;
            rem_r     <= '0;
            step      <= '0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        if (Divisor == '0) begin
                            state     <= DONE;
                            Done      <= 1'b1;
                            Quotient  <= '1;
                            Remainder <= Dividend;
                            DivByZero <= 1'b1;
                        end else begin
                            state  <= BUSY;
                            Busy   <= 1'b1;
                            quo_sr <= dvd_in;
                            dvs_r  <= dvs_in;
                            rem_r  <= '0;
                            step   <= '0;
`ifdef SEQ_DIVIDER_SIGNED_EN
                            q_neg  <= Dividend[WIDTH-1] ^ Divisor[WIDTH-1];
                            r_neg  <= Dividend[WIDTH-1];
`endif
                        end
                    end
                end
                BUSY: begin
                    quo_sr <= q_next;
                    rem_r  <= r_next;
                    step   <= step + 1'b1;
                    if (step == CW'(WIDTH - 1)) begin
                        state     <= DONE;
                        Busy      <= 1'b0;
                        Done      <= 1'b1;
                        Quotient  <= q_fin;
                        Remainder <= r_fin;
                        DivByZero <= 1'b0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    Done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                    Done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (WIDTH=4): arithmetic reference model, directed and random stimulus.
module tb_seq_divider;

    logic       clk = 1'b0;
    logic       rst;
    logic       Start;
    logic [3:0] Dividend;
    logic [3:0] Divisor;
    logic       Busy;
    logic       Done;
    logic [3:0] Quotient;
    logic [3:0] Remainder;
    logic       DivByZero;

    int errors = 0;
    int checks = 0;

    seq_divider #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .Start     (Start),
        .Dividend  (Dividend),
        .Divisor   (Divisor),
        .Busy      (Busy),
        .Done      (Done),
        .Quotient  (Quotient),
        .Remainder (Remainder),
        .DivByZero (DivByZero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference arithmetic straight from the definition of division.
    function automatic void ref_div(input logic [3:0] a, input logic [3:0] b,
                                    output logic [3:0] q, output logic [3:0] r, output logic dz);
`ifdef SEQ_DIVIDER_SIGNED_EN
        int sa;
        int sb;
        sa = $signed(a);
        sb = $signed(b);
        if (b == 4'd0) begin
            q = 4'hF; r = a; dz = 1'b1;
        end else begin
            q = 4'(sa / sb); r = 4'(sa % sb); dz = 1'b0;
        end
`else
        if (b == 4'd0) begin
            q = 4'hF; r = a; dz = 1'b1;
        end else begin
            q = a / b; r = a % b; dz = 1'b0;
        end
`endif
    endfunction

    // Transaction-level model: idle, counting down a busy window of 4 cycles, or a done cycle.
    logic       exp_busy, exp_done, exp_dz;
    logic [3:0] exp_q, exp_r;
    logic [3:0] pend_q, pend_r;
    logic       pend_dz;
    int         busy_left;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_busy = 1'b0; exp_done = 1'b0; exp_dz = 1'b0;
            exp_q = 4'd0; exp_r = 4'd0; busy_left = 0;
        end else if (exp_done) begin
            exp_done = 1'b0;
        end else if (exp_busy) begin
            busy_left--;
            if (busy_left == 0) begin
                exp_busy = 1'b0; exp_done = 1'b1;
                exp_q = pend_q; exp_r = pend_r; exp_dz = pend_dz;
            end
        end else if (Start) begin
            ref_div(Dividend, Divisor, pend_q, pend_r, pend_dz);
            if (pend_dz) begin
                exp_done = 1'b1; exp_q = pend_q; exp_r = pend_r; exp_dz = 1'b1;
            end else begin
                exp_busy = 1'b1; busy_left = 4;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("busy", Busy, exp_busy);
            check("done", Done, exp_done);
            check("quotient", Quotient, exp_q);
            check("remainder", Remainder, exp_r);
            check("divbyzero", DivByZero, exp_dz);
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, Busy, 1'b0);
        check({tag, "_done"}, Done, 1'b0);
        check({tag, "_quotient"}, Quotient, 4'd0);
        check({tag, "_remainder"}, Remainder, 4'd0);
        check({tag, "_divbyzero"}, DivByZero, 1'b0);
    endtask

    // Called at posedge+1 in IDLE; returns at posedge+1 just after the accepting edge.
    task automatic launch(input logic [3:0] a, input logic [3:0] b);
        Start = 1'b1; Dividend = a; Divisor = b;
        @(posedge clk); #1;
        Start = 1'b0;
    endtask

    // lat counts edges from acceptance (inclusive) to the start of the Done cycle.
    task automatic wait_done(input int start_lat, output int lat);
        lat = start_lat;
        while (!Done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!Done) begin
            checks++; errors++;
            $display("FAIL done_timeout: got no Done after %0d edges required Done", lat);
        end
    endtask

    task automatic check_result(input string tag, input int lat, input int req_lat,
                                input logic [3:0] q, input logic [3:0] r, input logic dz);
        check({tag, "_latency"}, 16'(lat), 16'(req_lat));
        check({tag, "_quotient"}, Quotient, q);
        check({tag, "_remainder"}, Remainder, r);
        check({tag, "_divbyzero"}, DivByZero, dz);
    endtask

`ifdef SEQ_DIVIDER_SIGNED_EN
    localparam logic [3:0] E13_Q = 4'hF, E13_R = 4'h0, E15_Q = 4'h0, E15_R = 4'hF;
`else
    localparam logic [3:0] E13_Q = 4'd4, E13_R = 4'd1, E15_Q = 4'd3, E15_R = 4'd3;
`endif

    initial begin
        int lat;
        int done_seen;
        rst = 1'b1; Start = 1'b0; Dividend = 4'd0; Divisor = 4'd0;
        #1;
        check_reset_outputs("reset_state");
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        launch(4'd13, 4'd3);
        wait_done(1, lat);
        check_result("div_13_3", lat, 5, E13_Q, E13_R, 1'b0);
        @(posedge clk); #1;

        launch(4'd7, 4'd0);
        wait_done(1, lat);
        check_result("div_7_0", lat, 1, 4'hF, 4'd7, 1'b1);
        @(posedge clk); #1;

        launch(4'd15, 4'd4);
        Start = 1'b1; Dividend = 4'd2; Divisor = 4'd1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        Start = 1'b0;
        wait_done(3, lat);
        check_result("restart_ignored", lat, 5, E15_Q, E15_R, 1'b0);
        @(posedge clk); #1;

        launch(4'd12, 4'd5);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("abort");
        done_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (Done) done_seen++;
        end
        check("abort_no_done", 16'(done_seen), 16'd0);
        Start = 1'b1; Dividend = 4'd9; Divisor = 4'd9;
        rst = 1'b0;
        @(posedge clk); #1;
        Start = 1'b0;
        wait_done(1, lat);
        check_result("after_reset_9_9", lat, 5, 4'd1, 4'd0, 1'b0);
        @(posedge clk); #1;

`ifdef SEQ_DIVIDER_SIGNED_EN
        launch(4'h9, 4'h2);
        wait_done(1, lat);
        check_result("signed_m7_2", lat, 5, 4'hD, 4'hF, 1'b0);
        @(posedge clk); #1;
        launch(4'h8, 4'hF);
        wait_done(1, lat);
        check_result("signed_m8_m1", lat, 5, 4'h8, 4'h0, 1'b0);
        @(posedge clk); #1;
`endif

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                launch(4'(a), 4'(b));
                wait_done(1, lat);
                check("sweep_latency", 16'(lat), (b == 0) ? 16'd1 : 16'd5);
                @(posedge clk); #1;
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                end
            end
        end

        for (int c = 0; c < 2000; c++) begin
            Start    = ($urandom_range(0, 2) == 0);
            Dividend = 4'($urandom);
            Divisor  = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom);
            if ($urandom_range(0, 199) == 0) begin
                #2;
                rst = 1'b1;
                #1;
                check_reset_outputs("random_reset");
                @(negedge clk);
                rst = 1'b0;
            end
            @(posedge clk); #1;
        end
        Start = 1'b0;
        repeat (8) @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
